// File: rtl/serial_add_sequencer.sv
// Bit-serial add/subtract sequencer driving one external full_adder cell, LSB first.
// Optional `define SERIAL_ADD_ABORT_EN adds an abort input that cancels a run in progress.
module serial_add_sequencer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_ABORT_EN
    input  logic             abort,
`endif
    output logic             ready,
    output logic             valid,
    input  logic             ack,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_s,
    input  logic             fa_cout
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] res_sh;
    logic             op_r;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             last_bit;
    logic             abort_hit;

`ifdef SERIAL_ADD_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    assign last_bit = (cnt == CW'(WIDTH - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, handshake flags and adder-cell drive
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        valid     = 1'b0;
        fa_a      = 1'b0;
        fa_b      = 1'b0;
        fa_cin    = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                fa_a   = a_sh[0];
                fa_b   = b_sh[0] ^ op_r;
                fa_cin = carry;
                if (abort_hit) begin
                    state_nxt = IDLE;
                end else if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                valid = 1'b1;
                if (ack) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand shifters, running carry and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            op_r   <= 1'b0;
            carry  <= 1'b0;
            cnt    <= '0;
            s      <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        op_r  <= op;
                        carry <= op;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    if (!abort_hit) begin
                        a_sh   <= a_sh >> 1;
                        b_sh   <= b_sh >> 1;
                        res_sh <= (WIDTH-1)'({fa_s, res_sh} >> 1);
                        carry  <= fa_cout;
                        if (last_bit) begin
                            // Overflow is carry into the MSB xor carry out of it
                            s    <= {fa_s, res_sh};
                            cout <= fa_cout;
                            ovf  <= carry ^ fa_cout;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Randomised self-checking bench for serial_add_sequencer against an arithmetic reference model.
module tb_serial_add_sequencer;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         abort;
    logic         ready;
    logic         valid;
    logic         ack;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
    logic         fa_a;
    logic         fa_b;
    logic         fa_cin;
    logic         fa_s;
    logic         fa_cout;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] last_s;
    logic         last_cout;
    logic         last_ovf;

    serial_add_sequencer #(.WIDTH(W)) dut (
        .clk     (clk),
`ifdef SERIAL_ADD_ABORT_EN
        .abort   (abort),
`endif
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .ready   (ready),
        .valid   (valid),
        .ack     (ack),
        .s       (s),
        .cout    (cout),
        .ovf     (ovf),
        .fa_a    (fa_a),
        .fa_b    (fa_b),
        .fa_cin  (fa_cin),
        .fa_s    (fa_s),
        .fa_cout (fa_cout)
    );

    // External full_adder cell
    assign fa_s    = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (ready !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("ready_wait", 64'(ready), 64'(1));
    endtask

    task automatic check_fa_idle(input string tag);
        check_eq(tag, 64'({fa_a, fa_b, fa_cin}), 64'(0));
    endtask

    // One full operation; chaos toggles ignored inputs during RUN and DONE
    task automatic run_op(input logic o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                          input int hold, input bit chaos);
        logic [W-1:0] bx;
        logic [W:0]   sum9;
        logic [W-1:0] cv;
        logic [W-1:0] exp_s;
        logic         exp_cout;
        logic         exp_ovf;
        bx       = o ? ~bb : bb;
        sum9     = {1'b0, aa} + {1'b0, bx} + {{W{1'b0}}, o};
        exp_s    = sum9[W-1:0];
        exp_cout = sum9[W];
        exp_ovf  = (aa[W-1] == bx[W-1]) && (exp_s[W-1] != aa[W-1]);
        cv       = exp_s ^ aa ^ bx;

        wait_ready();
        check_fa_idle("fa_idle");
        start = 1'b1;
        op    = o;
        a     = aa;
        b     = bb;
        @(posedge clk);
        #1;
        if (!chaos) start = 1'b0;
        check_eq("ready_run", 64'(ready), 64'(0));
        for (int i = 0; i < int'(W); i++) begin
            check_eq("fa_a", 64'(fa_a), 64'(aa[i]));
            check_eq("fa_b", 64'(fa_b), 64'(bb[i] ^ o));
            check_eq("fa_cin", 64'(fa_cin), 64'(cv[i]));
            check_eq("valid_run", 64'(valid), 64'(0));
            if (chaos) begin
                start = 1'($urandom);
                ack   = 1'($urandom);
                op    = 1'($urandom);
                a     = (i == 3) ? '0 : W'($urandom);
                b     = (i == 3) ? '0 : W'($urandom);
            end
            @(posedge clk);
            #1;
        end
        ack = 1'b0;
        check_eq("valid_done", 64'(valid), 64'(1));
        check_eq("ready_done", 64'(ready), 64'(0));
        check_eq("s", 64'(s), 64'(exp_s));
        check_eq("cout", 64'(cout), 64'(exp_cout));
        check_eq("ovf", 64'(ovf), 64'(exp_ovf));
        check_fa_idle("fa_done");
        for (int h = 0; h < hold; h++) begin
            if (chaos) start = 1'($urandom);
            @(posedge clk);
            #1;
            check_eq("valid_hold", 64'(valid), 64'(1));
            check_eq("s_hold", 64'(s), 64'(exp_s));
        end
        ack   = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        ack = 1'b0;
        check_eq("ready_after_ack", 64'(ready), 64'(1));
        check_eq("valid_after_ack", 64'(valid), 64'(0));
        check_eq("s_kept", 64'({s, cout, ovf}), 64'({exp_s, exp_cout, exp_ovf}));
        last_s    = exp_s;
        last_cout = exp_cout;
        last_ovf  = exp_ovf;
    endtask

`ifdef SERIAL_ADD_ABORT_EN
    task automatic abort_at(input int k, input logic o, input logic [W-1:0] aa, input logic [W-1:0] bb);
        wait_ready();
        start = 1'b1;
        op    = o;
        a     = aa;
        b     = bb;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < k; i++) begin
            @(posedge clk);
            #1;
            check_eq("valid_pre_abort", 64'(valid), 64'(0));
        end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check_eq("ready_abort", 64'(ready), 64'(1));
        check_eq("s_abort_kept", 64'({s, cout, ovf}), 64'({last_s, last_cout, last_ovf}));
        for (int i = 0; i < int'(W) + 2; i++) begin
            check_eq("valid_after_abort", 64'(valid), 64'(0));
            @(posedge clk);
            #1;
        end
        check_eq("ready_idle_abort", 64'(ready), 64'(1));
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        op        = 1'b0;
        a         = '0;
        b         = '0;
        abort     = 1'b0;
        ack       = 1'b0;
        last_s    = '0;
        last_cout = 1'b0;
        last_ovf  = 1'b0;
        #2;
        check_eq("rst_ready", 64'(ready), 64'(1));
        check_eq("rst_valid", 64'(valid), 64'(0));
        check_eq("rst_result", 64'({s, cout, ovf}), 64'(0));
        check_fa_idle("rst_fa");
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op(1'b0, 8'h7F, 8'h01, 0, 1'b0);
        run_op(1'b0, 8'hFF, 8'h01, 1, 1'b0);
        run_op(1'b1, 8'h05, 8'h07, 2, 1'b0);
        run_op(1'b1, 8'h80, 8'h01, 0, 1'b0);
        run_op(1'b0, 8'h3C, 8'h5A, 10, 1'b1);

        // Asynchronous reset in the middle of a run
        wait_ready();
        start = 1'b1;
        op    = 1'b0;
        a     = 8'h55;
        b     = 8'h22;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_s", 64'(s), 64'(0));
        check_eq("arst_valid", 64'(valid), 64'(0));
        check_eq("arst_ready", 64'(ready), 64'(1));
        check_fa_idle("arst_fa");
        #2;
        rst_n = 1'b1;
        last_s    = '0;
        last_cout = 1'b0;
        last_ovf  = 1'b0;
        @(posedge clk);
        #1;
        run_op(1'b1, 8'h10, 8'h20, 1, 1'b0);

`ifdef SERIAL_ADD_ABORT_EN
        abort_at(4, 1'b0, 8'h12, 8'h34);
        abort_at(7, 1'b1, 8'h01, 8'h02);
        run_op(1'b0, 8'h01, 8'h02, 0, 1'b0);
`endif

        for (int t = 0; t < 40; t++) begin
            run_op(1'($urandom), W'($urandom), W'($urandom),
                   int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_add_sequencer.md
Name: serial_add_sequencer

Overview:
Bit-serial add/subtract controller that time-shares one external full_adder cell across a WIDTH-bit operation, LSB first.
- Latches operands on a START handshake.
- Drives the full_adder cell's A/B/Cin once per clock and collects its S/Cout.
- Keeps the running carry in a flop.
- Presents the WIDTH-bit result with a VALID/ACK handshake.
- Serves as the area-minimal ALU adder path next to the single-cycle datapath.

Parameters:
WIDTH, 8, operand/result width in bits (legal range 2..64)

Ports:
CLK  in  1  sole clock, rising-edge
RST_N  in  1  asynchronous active-low reset
START  in  1  request; accepted only when READY=1
OP  in  1  0 = add, 1 = subtract (A - B); sampled with START
A  in  WIDTH  operand A; sampled with START
B  in  WIDTH  operand B; sampled with START
READY  out  1  high in IDLE only
VALID  out  1  result available; held until ACK
ACK  in  1  result consumed
S  out  WIDTH  result; stable while VALID=1
COUT  out  1  final carry (for subtract: 1 = no borrow)
OVF  out  1  signed overflow
FA_A  out  1  to full_adder A
FA_B  out  1  to full_adder B
FA_CIN  out  1  to full_adder Cin
FA_S  in  1  from full_adder S
FA_COUT  in  1  from full_adder Cout

Behaviour:
- Clock and reset: one clock, CLK. RST_N is asynchronous and active-low. Reset forces state to IDLE, clears all registers, and sets S=0, COUT=0, OVF=0, VALID=0, READY=1, FA_A=FA_B=FA_CIN=0.
- States: IDLE, RUN, DONE. READY=1 only in IDLE; VALID=1 only in DONE.
- IDLE:
  - START=1 at an edge loads a_sh=A, b_sh=B, op_r=OP, carry=OP, bit counter cnt=0, and moves to RUN.
  - START=0 stays in IDLE.
- RUN:
  - Combinational drive: FA_A=a_sh[0], FA_B=b_sh[0]^op_r, FA_CIN=carry.
  - Each edge: a_sh and b_sh shift right; result register shifts right with FA_S entering bit WIDTH-1; carry<=FA_COUT; cnt<=cnt+1.
  - At the edge where cnt==WIDTH-1, capture OVF = carry ^ FA_COUT (carry into MSB xor carry out), capture COUT=FA_COUT, and move to DONE.
- Latency: START accepted at edge k, VALID=1 after edge k+WIDTH, i.e. exactly WIDTH cycles. The adder is used for exactly WIDTH cycles per operation.
- DONE:
  - S, COUT and OVF are stable.
  - ACK=1 at an edge moves to IDLE; VALID falls and READY rises after that edge.
  - S, COUT and OVF keep their value until the next result is produced.
  - With no ACK, DONE is held indefinitely.
- Ignored inputs:
  - START in RUN or DONE is ignored; no queuing.
  - ACK outside DONE is ignored.
  - Changes on A, B and OP after acceptance have no effect.
- Outside RUN, FA_A, FA_B and FA_CIN are forced to 0.
- Arithmetic: result is (A + (OP ? ~B : B) + OP) mod 2^WIDTH, i.e. two's complement.
- Reset mid-operation: immediate abort to the reset values above; partial result discarded.
- cnt is sized $clog2(WIDTH) bits; no wrap occurs because the exit is at WIDTH-1.

Optional Feature:
SERIAL_ADD_ABORT_EN
- Defined:
  - Adds input port ABORT (1 bit).
  - ABORT=1 at an edge in RUN returns to IDLE at that edge without asserting VALID; S, COUT and OVF keep their previous values.
  - ABORT in IDLE or DONE is ignored.
  - ABORT has priority over completion at cnt==WIDTH-1.
- Undefined: no ABORT port; RUN always completes.

Test Plan:
- WIDTH=8, OP=0, A=0x7F, B=0x01, START pulse in IDLE -> VALID high exactly 8 cycles after accept; S=0x80, COUT=0, OVF=1.
- OP=0, A=0xFF, B=0x01 -> S=0x00, COUT=1, OVF=0. Then OP=1, A=0x05, B=0x07 -> S=0xFE, COUT=0, OVF=0.
- OP=1, A=0x80, B=0x01 -> S=0x7F, COUT=1, OVF=1. FA_CIN=1 in the first RUN cycle; FA_* are 0 in IDLE and DONE.
- START held high through RUN, and A/B changed to 0x00 mid-run -> one operation only, result unchanged. VALID held for 10 cycles with ACK=0, then ACK=1 -> READY=1 next cycle.
- RST_N low asynchronously at cnt=3 of a run -> S=0, VALID=0, READY=1 without waiting for a clock edge. A new START after release gives a correct result.
- With SERIAL_ADD_ABORT_EN defined: ABORT at cnt=4 -> IDLE next edge, VALID never asserted, previous S retained. ABORT at cnt=7 beats completion.
